layer_alpha_blender: RTL

Parametrised, pipelined successor to the priority palette mixer. Takes NUM_LAYERS already-palettised pixels (4-bit alpha plus 24-bit RGB each) and composites them back-to-front with true per-layer alpha blending over a programmable background colour. The pipeline has one register stage per layer and advances on the shared pixel-clock enable. It sits between the palette RAM outputs and the video output encoder, and delays the sync/sideband bits by the same amount so they stay aligned.

---
 rtl/layer_alpha_blender.sv | 118 +++++++++++
 1 files changed

// File: rtl/layer_alpha_blender.sv
// layer_alpha_blender
// Composites NUM_LAYERS palettised layers back-to-front over BG_COLOR.
// Stage 0 registers the inputs and seeds the accumulator with BG_COLOR.
// Stage s then blends layer NUM_LAYERS-s over that accumulator. Upper-layer
// alpha and RGB values ride along in skew registers, so each layer meets its
// own pixel. The pipeline only advances on cycles where pc_ena_in == 0.
//
// Build option: define LAYER_ALPHA_BLEND_EN to get the arithmetic alpha blend.
// Without it, each stage is a mux that takes the layer colour when alpha[3]
// is set. No multipliers are built in that case. Latency, sideband and
// out_valid behave the same in both builds.

module layer_alpha_blender #(
    parameter int          NUM_LAYERS = 5,
    parameter int          SIDEBAND_W = 3,
    parameter logic [23:0] BG_COLOR   = 24'h000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [3:0]              pc_ena_in,
    input  logic [4*NUM_LAYERS-1:0] layer_alpha,
    input  logic [24*NUM_LAYERS-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]   layer_active,
    input  logic [NUM_LAYERS-1:0]   layer_ena,
    input  logic [SIDEBAND_W-1:0]   sideband_in,
    output logic [7:0]              pixel_out_r,
    output logic [7:0]              pixel_out_g,
    output logic [7:0]              pixel_out_b,
    output logic [SIDEBAND_W-1:0]   sideband_out,
    output logic                    out_valid
);

    localparam int CNT_W = $clog2(NUM_LAYERS + 2);
    localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(NUM_LAYERS + 1);

    logic                  advance;
    logic [3:0]            a_eff   [NUM_LAYERS];
    // [stage][layer]: the copy of each layer's alpha/RGB held alongside stage s
    logic [3:0]            alpha_q [NUM_LAYERS][NUM_LAYERS];
    logic [23:0]           rgb_q   [NUM_LAYERS][NUM_LAYERS];
    logic [23:0]           acc_q   [NUM_LAYERS+1];
    logic [SIDEBAND_W-1:0] sb_q    [NUM_LAYERS+1];
    logic [CNT_W-1:0]      fill_cnt;

    assign advance = (pc_ena_in == 4'd0);

    // One channel of the per-layer compositing step.
    function automatic logic [7:0] mix_ch(input logic [7:0] c, input logic [7:0] acc,
                                          input logic [3:0] a);
`ifdef LAYER_ALPHA_BLEND_EN
        logic [4:0] w;
        // Weight runs 0..16, so alpha 15 replaces acc exactly and alpha 0 keeps it.
        w = {1'b0, a} + {4'b0000, a[3]};
        return 8'(((13'(c) * 13'(w)) + (13'(acc) * 13'(5'd16 - w))) >> 4);
`else
        return a[3] ? c : acc;
`endif
    endfunction

    function automatic logic [23:0] mix_px(input logic [23:0] c, input logic [23:0] acc,
                                           input logic [3:0] a);
        return {mix_ch(c[23:16], acc[23:16], a),
                mix_ch(c[15:8],  acc[15:8],  a),
                mix_ch(c[7:0],   acc[7:0],   a)};
    endfunction

    // A layer is transparent unless it is both video-active and enabled.
    always_comb begin
        for (int k = 0; k < NUM_LAYERS; k++) begin
            a_eff[k] = (layer_active[k] & layer_ena[k]) ? layer_alpha[4*k +: 4] : 4'd0;
        end
    end

    // Pixel pipeline, skew registers, sideband delay line and fill counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < NUM_LAYERS; s++) begin
                for (int k = 0; k < NUM_LAYERS; k++) begin
                    alpha_q[s][k] <= '0;
                    rgb_q[s][k]   <= '0;
                end
            end
            for (int s = 0; s <= NUM_LAYERS; s++) begin
                acc_q[s] <= '0;
                sb_q[s]  <= '0;
            end
            fill_cnt <= '0;
        end else if (advance) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                alpha_q[0][k] <= a_eff[k];
                rgb_q[0][k]   <= layer_rgb[24*k +: 24];
            end
            acc_q[0] <= BG_COLOR;
            sb_q[0]  <= sideband_in;
            for (int s = 1; s < NUM_LAYERS; s++) begin
                for (int k = 0; k < NUM_LAYERS; k++) begin
                    alpha_q[s][k] <= alpha_q[s-1][k];
                    rgb_q[s][k]   <= rgb_q[s-1][k];
                end
            end
            for (int s = 1; s <= NUM_LAYERS; s++) begin
                acc_q[s] <= mix_px(rgb_q[s-1][NUM_LAYERS-s], acc_q[s-1],
                                   alpha_q[s-1][NUM_LAYERS-s]);
                sb_q[s]  <= sb_q[s-1];
            end
            if (fill_cnt != FILL_FULL) begin
                fill_cnt <= fill_cnt + CNT_W'(1);
            end
        end
    end

    assign pixel_out_r  = acc_q[NUM_LAYERS][23:16];
    assign pixel_out_g  = acc_q[NUM_LAYERS][15:8];
    assign pixel_out_b  = acc_q[NUM_LAYERS][7:0];
    assign sideband_out = sb_q[NUM_LAYERS];
    assign out_valid    = (fill_cnt == FILL_FULL);

endmodule
